instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 176 +++++++++++++++++
 tb/tb_instr_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns class/field requests into 32-bit words,
// flags immediates that do not fit their format, and buffers the results
// in a 2-entry FIFO with a registered ready and a saturating error counter.
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  cls,
   input  logic        sub,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic        err,
   output logic [7:0]  err_count
);

   localparam logic [2:0] ClsLoad   = 3'd0;
   localparam logic [2:0] ClsStore  = 3'd1;
   localparam logic [2:0] ClsRtype  = 3'd2;
   localparam logic [2:0] ClsBranch = 3'd3;
   localparam logic [2:0] ClsItype  = 3'd4;
   localparam logic [2:0] ClsJal    = 3'd5;
   localparam logic [2:0] ClsUpper  = 3'd6;
   localparam logic [2:0] ClsJalr   = 3'd7;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   logic [31:0] encInstr;
   logic        encErr;
   logic        fitsI;
   logic        fitsB;
   logic        fitsJ;
   logic        isShift;

   logic [1:0]  countQ, countD;
   logic [31:0] headQ, headD;
   logic        headErrQ, headErrD;
   logic [31:0] tailQ, tailD;
   logic        tailErrQ, tailErrD;
   logic [7:0]  errCountQ, errCountD;
   logic        push;
   logic        pop;

   // Immediate range checks: upper bits must all equal the format's sign bit.
   always_comb begin
      fitsI   = (imm[31:11] == '0) || (imm[31:11] == '1);
      fitsB   = (imm[31:12] == '0) || (imm[31:12] == '1);
      fitsJ   = (imm[31:20] == '0) || (imm[31:20] == '1);
      isShift = (funct3 == 3'b001) || (funct3 == 3'b101);
   end

   // Field packing per class; truncated fields are still encoded when err is set.
   always_comb begin
      encInstr = '0;
      encErr   = 1'b0;
      unique case (cls)
         ClsLoad: begin
            encInstr = {imm[11:0], rs1, funct3, rd, OpLoad};
            encErr   = !fitsI;
         end
         ClsStore: begin
            encInstr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpStore};
            encErr   = !fitsI;
         end
         ClsRtype: begin
            encInstr = {1'b0, sub, 5'b0, rs2, rs1, funct3, rd, OpRtype};
         end
         ClsBranch: begin
            encInstr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBranch};
            encErr   = !fitsB || imm[0];
         end
         ClsItype: begin
            if (isShift) begin
               encInstr = {1'b0, sub, 5'b0, imm[4:0], rs1, funct3, rd, OpItype};
               encErr   = (imm[31:5] != '0);
            end else begin
               encInstr = {imm[11:0], rs1, funct3, rd, OpItype};
               encErr   = !fitsI;
            end
         end
         ClsJal: begin
            encInstr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
            encErr   = !fitsJ || imm[0];
         end
         ClsUpper: begin
            encInstr = {imm[31:12], rd, (sub ? OpLui : OpAuipc)};
            encErr   = (imm[11:0] != '0);
         end
         ClsJalr: begin
            encInstr = {imm[11:0], rs1, 3'b000, rd, OpJalr};
            encErr   = !fitsI;
         end
         default: begin
            encInstr = '0;
            encErr   = 1'b0;
         end
      endcase
   end

   // Ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = (countQ != 2'd2);
   assign out_valid = (countQ != 2'd0);
   assign instr     = headQ;
   assign err       = headErrQ;
   assign err_count = errCountQ;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // FIFO next state: head is the output register, tail holds the second word.
   always_comb begin
      countD    = countQ;
      headD     = headQ;
      headErrD  = headErrQ;
      tailD     = tailQ;
      tailErrD  = tailErrQ;
      errCountD = errCountQ;
      if (push && pop) begin
         // Push only happens below count 2, so here count is 1: replace head.
         headD    = encInstr;
         headErrD = encErr;
      end else if (push) begin
         countD = countQ + 2'd1;
         if (countQ == 2'd0) begin
            headD    = encInstr;
            headErrD = encErr;
         end else begin
            tailD    = encInstr;
            tailErrD = encErr;
         end
      end else if (pop) begin
         countD = countQ - 2'd1;
         if (countQ == 2'd2) begin
            headD    = tailQ;
            headErrD = tailErrQ;
         end
      end
      if (push && encErr && (errCountQ != 8'hFF)) begin
         errCountD = errCountQ + 8'd1;
      end
   end

   // State registers; synchronous reset overrides any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         countQ    <= 2'd0;
         headQ     <= '0;
         headErrQ  <= 1'b0;
         tailQ     <= '0;
         tailErrQ  <= 1'b0;
         errCountQ <= '0;
      end else begin
         countQ    <= countD;
         headQ     <= headD;
         headErrQ  <= headErrD;
         tailQ     <= tailD;
         tailErrQ  <= tailErrD;
         errCountQ <= errCountD;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver queues hand-computed words
// on acceptance, a negedge monitor pops and compares on each output handshake.
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  cls;
   logic        sub;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic        err;
   logic [7:0]  err_count;

   int unsigned nCompared;
   int unsigned nMismatched;
   int unsigned errModel;
   logic [32:0] sb[$];

   instr_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cls       (cls),
      .sub       (sub),
      .funct3    (funct3),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .err       (err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one request and hold it until accepted; called at posedge+1.
   task automatic send(input logic [2:0] c, input logic s, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] im, input logic [31:0] expInstr,
                       input logic expErr);
      bit done;
      done     = 1'b0;
      cls      = c;
      sub      = s;
      funct3   = f3;
      rd       = d;
      rs1      = r1;
      rs2      = r2;
      imm      = im;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back({expErr, expInstr});
            if (expErr && errModel < 255) errModel++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Monitor: every output handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", instr, 32'hxxxxxxxx);
         end else begin
            logic [32:0] e;
            e = sb.pop_front();
            check("instr", instr, e[31:0]);
            check("err", {31'd0, err}, {31'd0, e[32]});
         end
      end
   end

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      errModel    = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      cls         = '0;
      sub         = 1'b0;
      funct3      = '0;
      rd          = '0;
      rs1         = '0;
      rs2         = '0;
      imm         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_err_count", {24'd0, err_count}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b0;

      // First request right after reset, then one-cycle latency check.
      send(3'd0, 1'b0, 3'b010, 5'd5, 5'd2, 5'd0, 32'd8, 32'h00812283, 1'b0);
      check("load_latency", {31'd0, out_valid}, 32'd1);
      send(3'd2, 1'b0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
      send(3'd3, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
      send(3'd6, 1'b1, 3'b000, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0);
      send(3'd6, 1'b1, 3'b000, 5'd1, 5'd0, 5'd0, 32'h12345001, 32'h123450B7, 1'b1);
      check("err_count_one", {24'd0, err_count}, 32'd1);
      send(3'd1, 1'b0, 3'b010, 5'd0, 5'd2, 5'd3, 32'hFFFFFFF8, 32'hFE312C23, 1'b0);
      send(3'd4, 1'b0, 3'b000, 5'd4, 5'd4, 5'd0, 32'hFFFFFFFF, 32'hFFF20213, 1'b0);
      send(3'd4, 1'b1, 3'b101, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293, 1'b0);
      send(3'd4, 1'b0, 3'b001, 5'd1, 5'd1, 5'd0, 32'd32, 32'h00009093, 1'b1);
      send(3'd7, 1'b0, 3'b111, 5'd1, 5'd5, 5'd0, 32'd4, 32'h004280E7, 1'b0);
      send(3'd0, 1'b0, 3'b010, 5'd5, 5'd2, 5'd0, 32'd2048, 32'h80012283, 1'b1);
      send(3'd6, 1'b0, 3'b000, 5'd2, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF117, 1'b0);
      send(3'd5, 1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFFDFF0EF, 1'b0);
      send(3'd2, 1'b1, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);
      send(3'd3, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, 1'b1);
      send(3'd5, 1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h800000EF, 1'b1);
      check("err_count_model", {24'd0, err_count}, errModel);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: two words fill the FIFO, the third is held off.
      out_ready = 1'b0;
      send(3'd0, 1'b0, 3'b010, 5'd5, 5'd2, 5'd0, 32'd8, 32'h00812283, 1'b0);
      send(3'd0, 1'b0, 3'b010, 5'd6, 5'd2, 5'd0, 32'd8, 32'h00812303, 1'b0);
      cls      = 3'd0;
      rd       = 5'd7;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_head_hold", instr, 32'h00812283);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(3'd0, 1'b0, 3'b010, 5'd7, 5'd2, 5'd0, 32'd8, 32'h00812383, 1'b0);
      @(negedge clk);
      check("bp_drain_rate", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      repeat (2) @(posedge clk);
      #1;
      check("bp_drained", sb.size(), 32'd0);

      // Saturation: 300 bad branches push the counter to its ceiling.
      for (int i = 0; i < 300; i++) begin
         send(3'd3, 1'b0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, 1'b1);
      end
      check("err_count_sat", {24'd0, err_count}, 32'd255);
      check("err_count_sat_model", {24'd0, err_count}, errModel);
      repeat (3) @(posedge clk);
      #1;

      // Reset with a full FIFO discards both words and the counter.
      out_ready = 1'b0;
      send(3'd0, 1'b0, 3'b010, 5'd5, 5'd2, 5'd0, 32'd2048, 32'h80012283, 1'b1);
      send(3'd0, 1'b0, 3'b010, 5'd6, 5'd2, 5'd0, 32'd2048, 32'h80012303, 1'b1);
      check("pre_rst_full", {31'd0, in_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      errModel = 0;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
      out_ready = 1'b1;
      send(3'd2, 1'b0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("final_sb_empty", sb.size(), 32'd0);
      check("final_out_valid", {31'd0, out_valid}, 32'd0);
      check("final_err_count", {24'd0, err_count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
